// File: rtl/psum_acc_if.sv
// ---------------------------------------------------------------------------
// psum_acc_if -- handshake bundle for the partial-sum accumulator.
//
// Signal names keep the accumulator's own view: i_* are driven into the
// accumulator and o_* are driven by it.
//   i_start      : pulse that opens an accumulation window
//   i_len        : beats per window, sampled with i_start
//   i_sum_valid  : i_sum carries a beat
//   i_sum        : signed per-cycle sum from the MAC mux stage
//   o_sum_ready  : accumulator takes i_sum this cycle
//   o_psum_valid : o_psum holds a finished window result
//   o_psum       : signed saturated partial sum
//   i_psum_ready : downstream takes o_psum
//   o_ovf        : saturation seen in the current or last window
// Modports: slave = accumulator side, master = producer/consumer side.
// ---------------------------------------------------------------------------
interface psum_acc_if #(
    parameter int ASUMDWD = 18,
    parameter int ACCDWD  = 24,
    parameter int CNTWD   = 8
);
    logic                      i_start;
    logic [CNTWD-1:0]          i_len;
    logic                      i_sum_valid;
    logic signed [ASUMDWD-1:0] i_sum;
    logic                      o_sum_ready;
    logic                      o_psum_valid;
    logic signed [ACCDWD-1:0]  o_psum;
    logic                      i_psum_ready;
    logic                      o_ovf;

    modport slave (
        input  i_start, i_len, i_sum_valid, i_sum, i_psum_ready,
        output o_sum_ready, o_psum_valid, o_psum, o_ovf
    );

    modport master (
        output i_start, i_len, i_sum_valid, i_sum, i_psum_ready,
        input  o_sum_ready, o_psum_valid, o_psum, o_ovf
    );
endinterface

// File: rtl/psum_acc.sv
// ---------------------------------------------------------------------------
// psum_acc -- windowed saturating accumulator for MAC partial sums.
//
// An i_start with a non-zero i_len opens a window of i_len beats. Each
// accepted beat adds the sign-extended i_sum into a saturating ACCDWD-bit
// accumulator. The last beat's result is registered into o_psum and offered
// with o_psum_valid until the downstream takes it. A new window may be
// started in the same cycle as that handshake.
//
// Ports:
//   i_clk : clock, all state changes on the rising edge
//   i_rst : asynchronous active-high reset
//   bus   : psum_acc_if slave modport (start/len, sum in, psum out, ovf)
// ---------------------------------------------------------------------------
module psum_acc #(
    parameter int ASUMDWD = 18,
    parameter int ACCDWD  = 24,
    parameter int CNTWD   = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    psum_acc_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [CNTWD-1:0]         CNT_ONE = {{(CNTWD-1){1'b0}}, 1'b1};
    localparam logic signed [ACCDWD-1:0] ACC_MAX = {1'b0, {(ACCDWD-1){1'b1}}};
    localparam logic signed [ACCDWD-1:0] ACC_MIN = {1'b1, {(ACCDWD-1){1'b0}}};

    state_t                   state_q, state_d;
    logic signed [ACCDWD-1:0] acc_q, acc_d;
    logic [CNTWD-1:0]         cnt_q, cnt_d;
    logic [CNTWD-1:0]         len_q, len_d;
    logic signed [ACCDWD-1:0] psum_q, psum_d;
    logic                     psum_valid_q, psum_valid_d;
    logic                     ovf_q, ovf_d;

    // One extra bit of headroom: the sum of two in-range values can exceed
    // the ACCDWD range by at most one bit, so the top two bits disagreeing
    // means the result has left the representable range.
    logic signed [ACCDWD:0]   sum_wide;
    logic                     sat_hit;
    logic signed [ACCDWD-1:0] sat_sum;
    logic                     start_ok;
    logic                     beat;
    logic                     last_beat;

    always_comb begin
        sum_wide = {acc_q[ACCDWD-1], acc_q}
                 + {{(ACCDWD+1-ASUMDWD){bus.i_sum[ASUMDWD-1]}}, bus.i_sum};
        sat_hit  = sum_wide[ACCDWD] ^ sum_wide[ACCDWD-1];
        if (!sat_hit) begin
            sat_sum = sum_wide[ACCDWD-1:0];
        end else if (sum_wide[ACCDWD]) begin
            sat_sum = ACC_MIN;
        end else begin
            sat_sum = ACC_MAX;
        end
    end

    // Ready comes purely from the state register, so valid never feeds back
    // into ready combinationally.
    assign beat      = (state_q == ST_ACC) && bus.i_sum_valid;
    assign start_ok  = bus.i_start && (bus.i_len != '0);
    // len_q is never zero inside a window, so len_q-1 cannot wrap and a full
    // 2^CNTWD-1 beat window ends with the counter at 2^CNTWD-2.
    assign last_beat = (cnt_q == (len_q - CNT_ONE));

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        len_d        = len_q;
        psum_d       = psum_q;
        psum_valid_d = psum_valid_q;
        ovf_d        = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    len_d   = bus.i_len;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = ST_ACC;
                end
            end

            ST_ACC: begin
                if (beat) begin
                    acc_d = sat_sum;
                    ovf_d = ovf_q | sat_hit;
                    if (last_beat) begin
                        psum_d       = sat_sum;
                        psum_valid_d = 1'b1;
                        state_d      = ST_HOLD;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end

            ST_HOLD: begin
                if (bus.i_psum_ready) begin
                    psum_valid_d = 1'b0;
                    if (start_ok) begin
                        len_d   = bus.i_len;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                        state_d = ST_ACC;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            len_q        <= '0;
            psum_q       <= '0;
            psum_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            psum_q       <= psum_d;
            psum_valid_q <= psum_valid_d;
            ovf_q        <= ovf_d;
        end
    end

    assign bus.o_sum_ready  = (state_q == ST_ACC);
    assign bus.o_psum_valid = psum_valid_q;
    assign bus.o_psum       = psum_q;
    assign bus.o_ovf        = ovf_q;

endmodule

// File: tb/tb_psum_acc.sv
// ---------------------------------------------------------------------------
// tb_psum_acc -- directed bench for psum_acc with hand-computed results.
// Inputs change 1 time unit after the rising edge; outputs are read at the
// same point, i.e. they reflect the state loaded at that edge.
// ---------------------------------------------------------------------------
module tb_psum_acc;
    localparam int ASUMDWD = 18;
    localparam int ACCDWD  = 24;
    localparam int CNTWD   = 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    psum_acc_if #(.ASUMDWD(ASUMDWD), .ACCDWD(ACCDWD), .CNTWD(CNTWD)) bus ();

    psum_acc #(.ASUMDWD(ASUMDWD), .ACCDWD(ACCDWD), .CNTWD(CNTWD)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint observed, input longint expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end else begin
            $display("ok   %s: %0d", tag, observed);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a window: i_start held for one edge.
    task automatic start_win(input int len);
        bus.i_start = 1'b1;
        bus.i_len   = CNTWD'(len);
        tick();
        bus.i_start = 1'b0;
        bus.i_len   = '0;
    endtask

    task automatic beat(input int v);
        bus.i_sum_valid = 1'b1;
        bus.i_sum       = ASUMDWD'(v);
        tick();
        bus.i_sum_valid = 1'b0;
        bus.i_sum       = '0;
    endtask

    task automatic take_result();
        bus.i_psum_ready = 1'b1;
        tick();
        bus.i_psum_ready = 1'b0;
    endtask

    int seq1 [4] = '{10, -3, 7, 100};

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.i_start = 1'b0;
        bus.i_len = '0;
        bus.i_sum_valid = 1'b0;
        bus.i_sum = '0;
        bus.i_psum_ready = 1'b0;
        tick();
        tick();
        check("rst_sum_ready", bus.o_sum_ready, 0);
        check("rst_psum_valid", bus.o_psum_valid, 0);
        check("rst_psum", $signed(bus.o_psum), 0);
        check("rst_ovf", bus.o_ovf, 0);
        rst = 1'b0;
        tick();

        // Window of 4, continuous beats: 10-3+7+100 = 114
        start_win(4);
        check("w4_ready", bus.o_sum_ready, 1);
        for (int i = 0; i < 4; i++) begin
            check("w4_no_result_yet", bus.o_psum_valid, 0);
            beat(seq1[i]);
        end
        check("w4_valid", bus.o_psum_valid, 1);
        check("w4_psum", $signed(bus.o_psum), 114);
        check("w4_ovf", bus.o_ovf, 0);
        check("w4_hold_not_ready", bus.o_sum_ready, 0);
        take_result();
        check("w4_valid_drop", bus.o_psum_valid, 0);
        check("w4_psum_kept", $signed(bus.o_psum), 114);
        check("w4_idle_not_ready", bus.o_sum_ready, 0);

        // Window of 3 with valid gaps: counter must not move during gaps
        start_win(3);
        beat(-5);
        tick();
        tick();
        check("gap_ready", bus.o_sum_ready, 1);
        beat(-5);
        tick();
        tick();
        tick();
        check("gap_no_early_result", bus.o_psum_valid, 0);
        beat(-5);
        check("gap_valid", bus.o_psum_valid, 1);
        check("gap_psum", $signed(bus.o_psum), -15);
        take_result();

        // Max-length window driving positive saturation
        start_win(255);
        for (int i = 0; i < 255; i++) begin
            beat(131071);
        end
        check("sat_valid", bus.o_psum_valid, 1);
        check("sat_psum", $signed(bus.o_psum), 8388607);
        check("sat_ovf", bus.o_ovf, 1);

        // Hold with downstream stalled, start ignored while held
        bus.i_start = 1'b1;
        bus.i_len = CNTWD'(5);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_valid", bus.o_psum_valid, 1);
            check("hold_psum", $signed(bus.o_psum), 8388607);
            check("hold_not_ready", bus.o_sum_ready, 0);
        end
        // Handshake and restart in the same cycle
        bus.i_len = CNTWD'(2);
        bus.i_psum_ready = 1'b1;
        tick();
        bus.i_psum_ready = 1'b0;
        bus.i_start = 1'b0;
        bus.i_len = '0;
        check("direct_acc_ready", bus.o_sum_ready, 1);
        check("direct_valid_drop", bus.o_psum_valid, 0);
        check("direct_ovf_clear", bus.o_ovf, 0);
        beat(20);
        beat(-7);
        check("direct_valid", bus.o_psum_valid, 1);
        check("direct_psum", $signed(bus.o_psum), 13);
        check("direct_ovf", bus.o_ovf, 0);
        take_result();

        // Reset in the middle of a window
        start_win(4);
        beat(1);
        beat(2);
        rst = 1'b1;
        #1;
        check("mid_rst_ready", bus.o_sum_ready, 0);
        check("mid_rst_valid", bus.o_psum_valid, 0);
        check("mid_rst_psum", $signed(bus.o_psum), 0);
        check("mid_rst_ovf", bus.o_ovf, 0);
        tick();
        rst = 1'b0;
        tick();
        bus.i_sum_valid = 1'b1;
        bus.i_sum = ASUMDWD'(5);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_ready", bus.o_sum_ready, 0);
            check("post_rst_valid", bus.o_psum_valid, 0);
        end
        bus.i_sum_valid = 1'b0;
        bus.i_sum = '0;

        // Zero-length start is ignored
        start_win(0);
        check("len0_ready", bus.o_sum_ready, 0);
        tick();
        tick();
        check("len0_ready_later", bus.o_sum_ready, 0);
        check("len0_valid", bus.o_psum_valid, 0);

        // Negative saturation: 70 * -131072 = -9175040 clamps to -8388608
        start_win(70);
        for (int i = 0; i < 70; i++) begin
            beat(-131072);
        end
        check("neg_sat_valid", bus.o_psum_valid, 1);
        check("neg_sat_psum", $signed(bus.o_psum), -8388608);
        check("neg_sat_ovf", bus.o_ovf, 1);
        take_result();
        check("ovf_sticky_idle", bus.o_ovf, 1);

        // Single-beat window, ovf cleared by the accepted start
        start_win(1);
        check("len1_ovf_clear", bus.o_ovf, 0);
        beat(-1);
        check("len1_valid", bus.o_psum_valid, 1);
        check("len1_psum", $signed(bus.o_psum), -1);
        take_result();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
